square_bcd_display: RTL and testbench
=====================================

# square_bcd_display

Sequential binary-to-decimal display stage placed directly downstream of the 3-bit squarer. It accepts the squarer's 6-bit result over a valid/ready handshake and converts it to BCD with an iterative shift-and-add-3 (double-dabble) engine. It drives two active-low seven-segment digits, with leading-zero blanking on the tens digit. On the board, `SW[2:0]` feed the squarer, the squarer output feeds this block, and this block drives `HEX1`/`HEX0`.

## Interface
- `WIDTH`, 6: binary input width; conversion takes `WIDTH` cycles.
- `DIGITS`, 2: BCD digits produced. Legal only if 10^DIGITS > 2^WIDTH−1; otherwise elaboration fails.
- `CLOCK_50`  in  1  sole clock, rising edge.
- `RESET_N`  in  1  reset; asynchronous assert, active-low.
- `in_value`  in  `WIDTH`  binary value from squarer.
- `in_valid`  in  1  `in_value` is valid.
- `in_ready`  out  1  block can accept; combinational from state.
- `done`  out  1  one-cycle pulse when new digits are latched.
- `bcd`  out  `4*DIGITS`  latched BCD result; digit 0 (ones) in `[3:0]`.
- `HEX0`  out  7  ones digit, active-low, bit order gfedcba.
- `HEX1`  out  7  tens digit, active-low, gfedcba.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture `in_value` into the binary shift register, clear the BCD scratch register, load count=`WIDTH`, and go to CONV.
  - CONV: `in_ready`=0. Each cycle:
    - Add 3 to every scratch digit ≥5.
    - Shift {scratch, binary} left by 1.
    - Decrement count.
  - Leaving CONV: on the cycle count reaches 0, copy scratch to `bcd`, update `HEX0`/`HEX1`, pulse `done`, and return to IDLE.
- `in_value` is sampled only at acceptance. Changes during CONV are ignored. `in_valid` during CONV is not accepted and not queued.
- `in_valid` held high continuously causes re-conversion on every IDLE cycle. `done` still pulses once per conversion.
- Segment decode is shared by both digits:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10–15 never occur; decode them to 1111111.
- Blanking: if the tens digit is 0, `HEX1`=1111111. `HEX0` is never blanked, so 0 displays as a single "0".
- `bcd`, `HEX0` and `HEX1` are registered and hold their values until the next `done`.

## Timing
- Reset values (async, immediate):
  - State IDLE, so `in_ready`=1.
  - `done`=0, `bcd`=0.
  - `HEX0`=1000000 ("0"), `HEX1`=1111111 (blank).
  - Scratch and count cleared.
- Handshake: a transfer occurs at the rising edge where `in_valid`&&`in_ready`=1.
- Latency: acceptance at edge E0; adjust/shift at edges E1..E`WIDTH`. At E`WIDTH` (E6 by default), `bcd`/`HEX*` update and `done` rises, staying high until E`WIDTH`+1.
- `in_ready` rises after E`WIDTH`. The earliest next acceptance is E`WIDTH`+1, giving throughput of one conversion per `WIDTH`+1 cycles.
- Reset asserted mid-CONV aborts immediately: outputs return to reset values and no `done` is produced. Conversion restarts only on a fresh handshake after `RESET_N` deasserts.
- Reset asserted on the same edge as acceptance: reset wins and nothing is captured.

## Structure
- Package `square_disp_pkg` holds:
  - state enum {IDLE, CONV};
  - segment constants `SEG_0`..`SEG_9` and `SEG_BLANK`;
  - a function computing the minimum legal `DIGITS` for the parameter check.
- Sub-module `seg7_decode` (4-bit digit → 7-bit active-low segments, purely combinational) is instantiated once per digit. Blanking logic lives in the top block.
- The top block contains the FSM, counter, shift/add-3 datapath and output registers.

## Test plan
- Reset, then check with no input: `in_ready`=1, `HEX0`=1000000, `HEX1`=1111111, `bcd`=0x00, `done`=0.
- Accept 49 (7²) at E0: `done` high exactly at E6, `bcd`=0x49, `HEX1`=0011001, `HEX0`=0010000; `in_ready`=0 during E1..E6.
- Accept 9: `HEX1` blanked (1111111), `HEX0`=0010000, `bcd`=0x09. Accept 0: `HEX0`=1000000, `HEX1` blank.
- Accept 36, then pulse `in_valid` with 25 at E3: 25 is ignored and the result is `bcd`=0x36. Then accept 25 at E7: `bcd`=0x25 with `done` at E13.
- Accept 63 (all ones, WIDTH boundary): `bcd`=0x63, `HEX1`=0000010, `HEX0`=0110000.
- Accept 16, then assert `RESET_N`=0 at E3: outputs return to reset values and no `done` occurs. After release, accept 4: `bcd`=0x04 after 6 cycles.

Source files
------------

// File: rtl/square_disp_pkg.sv
// rtl/square_disp_pkg.sv - shared types, segment codes and parameter check helper
//
// Contents:
//   state_t          FSM state encoding {IDLE, CONV}
//   SEG_0..SEG_9     active-low gfedcba patterns for decimal digits
//   SEG_BLANK        all segments off
//   min_digits()     smallest BCD digit count able to hold 2^width-1
package square_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Smallest d with 10^d > 2^width - 1.
  function automatic int min_digits(input int width);
    int    d;
    longint lim;
    longint maxv;
    d    = 1;
    lim  = 10;
    maxv = (longint'(1) << width) - 1;
    for (int i = 0; i < 19; i++) begin
      if (lim <= maxv) begin
        d   = d + 1;
        lim = lim * 10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit BCD digit to active-low seven-segment pattern
//
// Ports:
//   digit  in   4  BCD digit (10..15 decode to blank)
//   seg    out  7  active-low segments, bit order gfedcba
module seg7_decode
  import square_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/square_bcd_display.sv
// rtl/square_bcd_display.sv - iterative double-dabble BCD converter driving two 7-seg digits
//
// Ports:
//   CLOCK_50  in   1           clock, rising edge
//   RESET_N   in   1           asynchronous active-low reset
//   in_value  in   WIDTH       binary value from the squarer
//   in_valid  in   1           in_value is valid
//   in_ready  out  1           block is idle and can accept
//   done      out  1           one-cycle pulse when new digits are latched
//   bcd       out  4*DIGITS    latched BCD result, ones digit in [3:0]
//   HEX0      out  7           ones digit, active-low gfedcba
//   HEX1      out  7           tens digit, active-low gfedcba, blanked when zero
module square_bcd_display
  import square_disp_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            HEX0,
  output logic [6:0]            HEX1
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("square_bcd_display: DIGITS too small for WIDTH");
  end

  state_t         state;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]  scratch;
  logic [BW-1:0]  adj;
  logic [BW-1:0]  next_scratch;
  logic [CW-1:0]  count;
  logic [3:0]     tens_next;
  logic [6:0]     seg_ones;
  logic [6:0]     seg_tens;

  assign in_ready = (state == IDLE);

  // One double-dabble step: add 3 to any digit >= 5, then shift the
  // binary MSB into the bottom of the scratch register. The bit shifted
  // out of the top digit is always zero when DIGITS is legal.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    next_scratch = BW'({adj, bin[WIDTH-1]});
  end

  if (DIGITS > 1) begin : g_tens
    assign tens_next = next_scratch[7:4];
  end else begin : g_no_tens
    assign tens_next = 4'd0;
  end

  // Decoders look at the value about to be latched so HEX* update on the
  // same edge as bcd.
  seg7_decode u_dec_ones (
    .digit (next_scratch[3:0]),
    .seg   (seg_ones)
  );

  seg7_decode u_dec_tens (
    .digit (tens_next),
    .seg   (seg_tens)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      bin     <= '0;
      scratch <= '0;
      count   <= '0;
      done    <= 1'b0;
      bcd     <= '0;
      HEX0    <= SEG_0;
      HEX1    <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin     <= in_value;
            scratch <= '0;
            count   <= CW'(WIDTH);
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= next_scratch;
          bin     <= bin << 1;
          count   <= count - 1'b1;
          // Last step: latch the post-shift value directly.
          if (count == CW'(1)) begin
            bcd   <= next_scratch;
            HEX0  <= seg_ones;
            HEX1  <= (tens_next == 4'd0) ? SEG_BLANK : seg_tens;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_bcd_display.sv
// tb/tb_square_bcd_display.sv - scoreboard bench for square_bcd_display
module tb_square_bcd_display;

  logic       clk;
  logic       rst_n;
  logic [5:0] in_value;
  logic       in_valid;
  logic       in_ready;
  logic       done;
  logic [7:0] bcd;
  logic [6:0] hex0;
  logic [6:0] hex1;

  int total;
  int bad;
  int cyc;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] h0;
    logic [6:0] h1;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  localparam logic [6:0] SEGS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  square_bcd_display #(.WIDTH(6), .DIGITS(2)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .in_value (in_value),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .done     (done),
    .bcd      (bcd),
    .HEX0     (hex0),
    .HEX1     (hex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int v, input int c);
    exp_t e;
    int tens;
    int ones;
    tens  = v / 10;
    ones  = v % 10;
    e.bcd = {4'(tens), 4'(ones)};
    e.h0  = SEGS[ones];
    e.h1  = (tens == 0) ? 7'b1111111 : SEGS[tens];
    e.cyc = c;
    return e;
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
        chk("bcd", 32'(bcd), 32'(e.bcd));
        chk("hex0", 32'(hex0), 32'(e.h0));
        chk("hex1", 32'(hex1), 32'(e.h1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted value; the accepting edge is E0, done expected at E0+6.
  task automatic send(input int v);
    chk("ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = 6'(v);
    tick();
    sb.push_back(mk(v, cyc + 6));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_hex0", 32'(hex0), 32'h40);
    chk("rst_hex1", 32'(hex1), 32'h7f);
    chk("rst_bcd", 32'(bcd), 32'h00);
    chk("rst_done", 32'(done), 32'd0);

    // 49: busy from after E0 through E5, ready again after E6
    send(49);
    for (int k = 0; k < 5; k++) begin
      chk("busy_49", 32'(in_ready), 32'd0);
      tick();
    end
    chk("busy_49_e5", 32'(in_ready), 32'd0);
    tick();
    chk("ready_after_e6", 32'(in_ready), 32'd1);
    drain();
    chk("bcd_49_held", 32'(bcd), 32'h49);

    send(9);
    drain();
    send(0);
    drain();

    // 36 with an ignored 25 pulse at E3, then 25 accepted at E7
    send(36);
    tick();
    tick();
    chk("busy_36", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_value = 6'd25;
    tick();
    in_valid = 1'b0;
    in_value = 6'd0;
    tick();
    tick();
    tick();
    send(25);
    drain();

    send(63);
    drain();

    // in_valid held high: back-to-back conversions at E0 and E7
    in_valid = 1'b1;
    in_value = 6'd17;
    tick();
    sb.push_back(mk(17, cyc + 6));
    repeat (6) tick();
    tick();
    sb.push_back(mk(17, cyc + 6));
    in_valid = 1'b0;
    drain();

    // Reset during conversion of 16 aborts it
    send(16);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h00);
    chk("abort_hex0", 32'(hex0), 32'h40);
    chk("abort_hex1", 32'(hex1), 32'h7f);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("abort_no_result", 32'(bcd), 32'h00);
    send(4);
    drain();

    tick();
    chk("final_done_low", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
